// File: rtl/pingpong_pkg.sv
// Shared types and default sizing for the ping-pong write arbiter.
package pingpong_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    STALL = 2'd2
  } state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first valid requester at or after ptr (wrapping),
// returned as one-hot plus index. Purely combinational.
module rr_select #(
  parameter int NUM_REQ = 4,
  localparam int IDXW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDXW-1:0]    idx,
  output logic               found
);

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (valid[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = IDXW'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pingpong_wr_arbiter.sv
// Round-robin burst arbiter feeding a ping-pong buffer write port.
// Define PPARB_STATS_EN to add per-requester transfer and stall counters.
module pingpong_wr_arbiter
  import pingpong_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     wclk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     full_i,
  output logic                     wen,
  output logic [WIDTH-1:0]         data_in
`ifdef PPARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(MAX_BURST + 1);

  state_t             state;
  logic [NUM_REQ-1:0] grant;
  logic [IDXW-1:0]    grant_idx;
  logic [IDXW-1:0]    rr_ptr;
  logic [CNTW-1:0]    burst_cnt;

  logic [NUM_REQ-1:0] sel_onehot;
  logic [IDXW-1:0]    sel_idx;
  logic               sel_found;
  logic               granted_valid;
  logic               last_word;
  logic [IDXW-1:0]    next_ptr;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .found  (sel_found)
  );

  // Gating with reset_n keeps the port quiet while reset is asserted, even
  // though the state register only clears at the next edge.
  assign req_ready     = (reset_n && state == BURST && !full_i) ? grant : '0;
  assign wen           = |(req_valid & req_ready);
  assign data_in       = req_data[grant_idx*WIDTH +: WIDTH];
  assign granted_valid = req_valid[grant_idx];
  assign last_word     = (burst_cnt == CNTW'(MAX_BURST - 1));
  assign next_ptr      = (grant_idx == IDXW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge wclk) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant     <= sel_onehot;
            grant_idx <= sel_idx;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (!granted_valid) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (full_i) begin
            state <= STALL;
          end else begin
            if (burst_cnt != CNTW'(MAX_BURST))
              burst_cnt <= burst_cnt + 1'b1;
            if (last_word) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end
          end
        end
        STALL: begin
          if (!granted_valid) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (!full_i) begin
            state <= BURST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PPARB_STATS_EN
  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge wclk) begin
    if (!reset_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (state == STALL && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_wr_arbiter.sv
// Self-checking bench for pingpong_wr_arbiter (WIDTH=8, NUM_REQ=4, MAX_BURST=4).
module tb_pingpong_wr_arbiter;

  localparam int NR   = 4;
  localparam int MAXB = 4;

  logic          wclk;
  logic          reset_n;
  logic [NR-1:0] req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          full_i;
  logic          wen;
  logic [7:0]    data_in;
`ifdef PPARB_STATS_EN
  logic [NR*16-1:0] grant_cnt;
  logic [15:0]      stall_cnt;
`endif

  logic [7:0] data_word [NR];
  int pass_cnt  = 0;
  int check_cnt = 0;

  // Reference model: who owns the port, how many words it has moved,
  // whether it is paused by a full buffer, and where the next search starts.
  int m_owner  = -1;
  int m_words  = 0;
  bit m_paused = 0;
  int m_next   = 0;
  int m_stall  = 0;
  int m_gcnt [NR] = '{default: 0};

  pingpong_wr_arbiter #(.WIDTH(8), .NUM_REQ(NR), .MAX_BURST(MAXB)) dut (
    .wclk      (wclk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full_i    (full_i),
    .wen       (wen),
    .data_in   (data_in)
`ifdef PPARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always_comb begin
    for (int i = 0; i < NR; i++) req_data[i*8 +: 8] = data_word[i];
  end

  function automatic logic [NR-1:0] exp_ready();
    if (reset_n && m_owner >= 0 && !m_paused && !full_i)
      return NR'(1 << m_owner);
    return '0;
  endfunction

  function automatic logic exp_wen();
    return |(req_valid & exp_ready());
  endfunction

  task automatic drive(input logic rn, input logic [NR-1:0] v, input logic f);
    reset_n   = rn;
    req_valid = v;
    full_i    = f;
    #2;
  endtask

  // Advance the model across one rising edge; requesters present their
  // next word (previous + 1) after each accepted one.
  task automatic tick();
    int j;
    bit hit;
    @(posedge wclk);
    if (!reset_n) begin
      m_owner = -1; m_words = 0; m_paused = 0; m_next = 0; m_stall = 0;
      for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
    end else if (m_owner < 0) begin
      hit = 0;
      for (int k = 0; k < NR; k++) begin
        j = (m_next + k) % NR;
        if (!hit && req_valid[j]) begin
          m_owner = j; hit = 1;
        end
      end
      m_words = 0; m_paused = 0;
    end else begin
      if (m_paused && m_stall < 65535) m_stall++;
      if (!req_valid[m_owner]) begin
        m_next = (m_owner + 1) % NR; m_owner = -1;
      end else if (m_paused) begin
        if (!full_i) m_paused = 0;
      end else if (full_i) begin
        m_paused = 1;
      end else begin
        m_words++;
        if (m_gcnt[m_owner] < 65535) m_gcnt[m_owner]++;
        data_word[m_owner] = data_word[m_owner] + 8'd1;
        if (m_words == MAXB) begin
          m_next = (m_owner + 1) % NR; m_owner = -1;
        end
      end
    end
    @(negedge wclk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 4'hF, 1'b0);
      check_cnt++;
      if (wen !== 1'b0) $display("[TB] FAIL reset_wen c%0d: got %b expected 0", c, wen);
      else pass_cnt++;
      check_cnt++;
      if (req_ready !== 4'b0000) $display("[TB] FAIL reset_ready c%0d: got %b expected 0000", c, req_ready);
      else pass_cnt++;
      tick();
    end
    drive(1'b1, 4'hF, 1'b0);
    check_cnt++;
    if (wen !== 1'b0 || req_ready !== 4'b0000)
      $display("[TB] FAIL reset_after: got wen=%b ready=%b expected wen=0 ready=0000", wen, req_ready);
    else pass_cnt++;
    tick();
    drive(1'b1, 4'hF, 1'b0);
    check_cnt++;
    if (req_ready !== 4'b0001 || wen !== 1'b1)
      $display("[TB] FAIL reset_first_grant: got wen=%b ready=%b expected wen=1 ready=0001", wen, req_ready);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] e;
    bit ew;
    drive(1'b0, 4'h0, 1'b0); tick();
    data_word[1] = 8'h10;
    e = 8'h10;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 4'b0010, 1'b0);
      ew = (c != 0 && c != 5);
      check_cnt++;
      if (wen !== ew || req_ready !== (ew ? 4'b0010 : 4'b0000))
        $display("[TB] FAIL single_flow c%0d: got wen=%b ready=%b expected wen=%b", c, wen, req_ready, ew);
      else pass_cnt++;
      if (ew) begin
        check_cnt++;
        if (data_in !== e) $display("[TB] FAIL single_data c%0d: got %h expected %h", c, data_in, e);
        else pass_cnt++;
        e = e + 8'd1;
      end
      tick();
    end
  endtask

  task automatic test_all_four();
    logic [NR-1:0] er;
    drive(1'b0, 4'h0, 1'b0); tick();
    for (int c = 0; c < 25; c++) begin
      drive(1'b1, 4'hF, 1'b0);
      er = (c % 5 == 0) ? 4'b0000 : NR'(1 << ((c / 5) % NR));
      check_cnt++;
      if (req_ready !== er || wen !== (er != 0))
        $display("[TB] FAIL rr_order c%0d: got ready=%b wen=%b expected ready=%b", c, req_ready, wen, er);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_stall();
    logic f;
    bit ew;
    drive(1'b0, 4'h0, 1'b0); tick();
    for (int c = 0; c < 10; c++) begin
      f  = (c >= 3 && c <= 5);
      ew = (c == 1 || c == 2 || c == 7 || c == 8);
      drive(1'b1, 4'b0001, f);
      check_cnt++;
      if (wen !== ew) $display("[TB] FAIL stall_wen c%0d: got %b expected %b", c, wen, ew);
      else pass_cnt++;
      tick();
    end
`ifdef PPARB_STATS_EN
    check_cnt++;
    if (stall_cnt !== 16'd3) $display("[TB] FAIL stall_cnt: got %0d expected 3", stall_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_drop();
    logic [NR-1:0] v_tab   [10] = '{4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000,
                                    4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1001};
    logic [NR-1:0] rdy_tab [10] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1000,
                                    4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    drive(1'b0, 4'h0, 1'b0); tick();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, v_tab[c], 1'b0);
      check_cnt++;
      if (req_ready !== rdy_tab[c] || wen !== |(v_tab[c] & rdy_tab[c]))
        $display("[TB] FAIL drop_release c%0d: got ready=%b wen=%b expected ready=%b", c, req_ready, wen, rdy_tab[c]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic rn_tab [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    logic [NR-1:0] rdy_tab [10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001,
                                    4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    drive(1'b0, 4'h0, 1'b0); tick();
    for (int c = 0; c < 10; c++) begin
      drive(rn_tab[c], 4'hF, 1'b0);
      check_cnt++;
      if (req_ready !== rdy_tab[c] || wen !== (rdy_tab[c] != 0))
        $display("[TB] FAIL reset_mid c%0d: got ready=%b wen=%b expected ready=%b", c, req_ready, wen, rdy_tab[c]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_random();
    logic rn, f;
    logic [NR-1:0] v, er;
    drive(1'b0, 4'h0, 1'b0); tick();
    for (int i = 0; i < NR; i++) data_word[i] = 8'($urandom_range(0, 255));
    for (int c = 0; c < 400; c++) begin
      rn = ($urandom_range(0, 59) != 0);
      f  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NR; i++) v[i] = ($urandom_range(0, 9) < 7);
      drive(rn, v, f);
      er = exp_ready();
      check_cnt++;
      if (req_ready !== er || wen !== exp_wen())
        $display("[TB] FAIL rand_ctrl c%0d: got ready=%b wen=%b expected ready=%b wen=%b",
                 c, req_ready, wen, er, exp_wen());
      else pass_cnt++;
      if (exp_wen()) begin
        check_cnt++;
        if (data_in !== data_word[m_owner])
          $display("[TB] FAIL rand_data c%0d: got %h expected %h", c, data_in, data_word[m_owner]);
        else pass_cnt++;
      end
      tick();
    end
`ifdef PPARB_STATS_EN
    check_cnt++;
    if (stall_cnt !== 16'(m_stall)) $display("[TB] FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, m_stall);
    else pass_cnt++;
    for (int i = 0; i < NR; i++) begin
      check_cnt++;
      if (grant_cnt[i*16 +: 16] !== 16'(m_gcnt[i]))
        $display("[TB] FAIL rand_grant_cnt%0d: got %0d expected %0d", i, grant_cnt[i*16 +: 16], m_gcnt[i]);
      else pass_cnt++;
    end
`endif
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    full_i    = 1'b0;
    for (int i = 0; i < NR; i++) data_word[i] = 8'(8'h40 * i);
    @(negedge wclk);
    $display("[TB] start");
    test_reset();
    test_single();
    test_all_four();
    test_stall();
    test_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/pingpong_wr_arbiter.md
PINGPONG_WR_ARBITER -- requirements
Module: pingpong_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning number of write requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning max words per grant (1..16).
REQ-004 SHALL have port wclk  input  1  write-domain clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester word-valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept, combinational.
REQ-009 SHALL have port full_i  input  1  ping-pong buffer full flag, wclk domain.
REQ-010 SHALL have port wen  output  1  buffer write enable, combinational.
REQ-011 SHALL have port data_in  output  WIDTH  buffer write data, combinational mux.

Function
REQ-012 SHALL implement FSM states IDLE, BURST, STALL; reset state IDLE.
REQ-013 IDLE: if any req_valid, SHALL register one-hot grant to the first valid requester at or after rr_ptr (wrapping), clear burst_cnt, go BURST; otherwise stay IDLE.
REQ-014 req_ready[i] SHALL equal (state==BURST) & grant[i] & ~full_i; all other bits 0.
REQ-015 wen SHALL equal |(req_valid & req_ready); data_in SHALL be req_data of granted requester; transfer latency zero cycles.
REQ-016 Each transfer SHALL increment burst_cnt ($clog2(MAX_BURST+1) bits, no wrap).
REQ-017 BURST: on transfer with burst_cnt==MAX_BURST-1, or granted req_valid low, SHALL release: rr_ptr <= (granted index+1) mod NUM_REQ, state IDLE.
REQ-018 BURST with full_i high and granted req_valid high SHALL go STALL; no transfer that cycle.
REQ-019 STALL: full_i low SHALL return to BURST with grant and burst_cnt kept; granted req_valid low SHALL release per REQ-017.
REQ-020 Release-then-regrant SHALL cost exactly one IDLE cycle (no write) between bursts.
REQ-021 Non-granted requesters SHALL see req_ready=0 and hold data; no word dropped or duplicated.

Reset
REQ-022 reset_n low at a wclk edge SHALL set state IDLE, grant 0, rr_ptr 0, burst_cnt 0, stats counters 0.
REQ-023 While in reset and the cycle after, wen and all req_ready SHALL be 0; reset mid-burst abandons the burst.

Configuration
REQ-024 With PPARB_STATS_EN defined, SHALL add outputs grant_cnt (NUM_REQ*16, per-requester transfers, saturating at 0xFFFF) and stall_cnt (16, cycles in STALL, saturating).
REQ-025 Without PPARB_STATS_EN, those ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-026 Package pingpong_pkg SHALL hold the FSM state enum typedef and default constants (WIDTH, NUM_REQ, MAX_BURST).
REQ-027 Round-robin selection (valid vector + pointer -> one-hot + index) SHALL be sub-module rr_select, purely combinational.

Verification (WIDTH=8, NUM_REQ=4, MAX_BURST=4)
REQ-028 reset_n low 2 cycles, all req_valid=1 -> wen=0, req_ready=0000 throughout, first grant to requester 0 one cycle after release.
REQ-029 Requester 1 only, data 0x10..0x17 -> writes 0x10-0x13 consecutive, one idle cycle, writes 0x14-0x17.
REQ-030 All four valid continuously -> grant order 0,1,2,3,0, 4 words each, one idle cycle between bursts.
REQ-031 full_i high 3 cycles after 2nd word of requester 0 -> wen=0 for those 3 cycles, stall_cnt=3, then words 3-4 written, burst ends.
REQ-032 Requester 2 drops valid after 1 word while 3 valid -> release, next grant requester 3, rr_ptr then 0.
REQ-033 reset_n low one cycle during word 2 of a burst -> wen=0 that and next cycle, next grant restarts at requester 0 with burst_cnt 0.
